// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data-memory and shared-memory handshakes for mem_arbiter.
// master is the arbiter's view; slave is the requesters' and memory's view.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port memory.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is data-over-fetch priority.
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_DM = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          grant_dm;
   logic          sel_dm;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] if_rdata_q;
   logic [DW-1:0] dm_rdata_q;
   logic          req_c;
   logic          if_ack_c;
   logic          dm_ack_c;

`ifdef MEM_ARB_RR_EN
   // Remembers who was served last so a tie goes to the other requester.
   logic last_dm;
   assign grant_dm = bus.dm_req && (!bus.if_req || !last_dm);
`else
   assign grant_dm = bus.dm_req;
`endif

   // NOTE: always_ff uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_nxt = state;
      req_c     = 1'b0;
      if_ack_c  = 1'b0;
      dm_ack_c  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.if_req || bus.dm_req) state_nxt = grant_dm ? GNT_DM : GNT_IF;
         end
         GNT_IF, GNT_DM: begin
            req_c = 1'b1;
            if (bus.mem_ready) state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
            if_ack_c  = !sel_dm;
            dm_ack_c  = sel_dm;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_dm     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_dm    <= 1'b1;
`endif
      end else begin
         if (state == IDLE && (bus.if_req || bus.dm_req)) begin
            sel_dm  <= grant_dm;
            we_q    <= grant_dm && bus.dm_we;
            addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
            wdata_q <= grant_dm ? bus.dm_wdata : '0;
`ifdef MEM_ARB_RR_EN
            last_dm <= grant_dm;
`endif
         end
         if (state == GNT_IF && bus.mem_ready) if_rdata_q <= bus.mem_rdata;
         // Stores complete with an ack but leave the load data register alone.
         if (state == GNT_DM && bus.mem_ready && !we_q) dm_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.mem_req   = req_c;
   assign bus.mem_we    = req_c && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_ack    = if_ack_c;
   assign bus.dm_ack    = dm_ack_c;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized self-checking bench for mem_arbiter.
// Expected arbitration order follows MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;

   logic clk;
   logic rst;

   mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Memory model controls.
   int          lat         = 1;
   int          cur_lat     = 1;
   int          wait_cnt    = 0;
   bit          rand_lat    = 1'b0;
   bit          use_hash    = 1'b0;
   bit          spur_ready  = 1'b0;
   logic [31:0] fixed_rdata = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model: answers in the cur_lat-th cycle of mem_req, driven on the falling edge.
   always @(negedge clk) begin
      if (bus.mem_req) begin
         if (wait_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
         bus.mem_ready = spur_ready || (wait_cnt == cur_lat - 1);
         wait_cnt++;
      end else begin
         bus.mem_ready = spur_ready;
         wait_cnt      = 0;
      end
      bus.mem_rdata = use_hash ? hash(bus.mem_addr) : fixed_rdata;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  exp_dm_win;
      logic [31:0] exp_if;
      logic [31:0] exp_dm;
      bit          if_pend;
      bit          dm_pend;
      int          if_issued;
      int          if_acked;
      int          dm_issued;
      int          dm_acked;
      int          cyc;

      rst          = 1'b1;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;

      // Reset state
      tick();
      tick();
      check("rst_mem_req",   bus.mem_req,   0);
      check("rst_mem_we",    bus.mem_we,    0);
      check("rst_if_ack",    bus.if_ack,    0);
      check("rst_dm_ack",    bus.dm_ack,    0);
      check("rst_mem_addr",  bus.mem_addr,  0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_if_rdata",  bus.if_rdata,  0);
      check("rst_dm_rdata",  bus.dm_rdata,  0);
      rst = 1'b0;
      tick();

      // Fetch, 1-cycle memory: ack in cycle 3
      lat         = 1;
      fixed_rdata = 32'h2008_0005;
      bus.if_addr = 32'h0000_0040;
      bus.if_req  = 1'b1;
      tick();
      check("f_mem_req",  bus.mem_req,  1);
      check("f_mem_addr", bus.mem_addr, 32'h40);
      check("f_mem_we",   bus.mem_we,   0);
      check("f_if_ack_c2", bus.if_ack,  0);
      tick();
      check("f_if_ack_c3",  bus.if_ack,   1);
      check("f_dm_ack_c3",  bus.dm_ack,   0);
      check("f_mem_req_c3", bus.mem_req,  0);
      check("f_if_rdata",   bus.if_rdata, 32'h2008_0005);
      bus.if_req = 1'b0;
      tick();
      check("f_if_ack_c4",   bus.if_ack,   0);
      check("f_if_rdata_c4", bus.if_rdata, 32'h2008_0005);

      // Data load, 2-cycle memory: ack in cycle 4
      lat          = 2;
      fixed_rdata  = 32'hCAFE_F00D;
      bus.dm_addr  = 32'h20;
      bus.dm_we    = 1'b0;
      bus.dm_req   = 1'b1;
      tick();
      check("ld_mem_addr", bus.mem_addr, 32'h20);
      check("ld_mem_we",   bus.mem_we,   0);
      tick();
      check("ld_mem_req_c3", bus.mem_req, 1);
      check("ld_dm_ack_c3",  bus.dm_ack,  0);
      tick();
      check("ld_dm_ack_c4", bus.dm_ack,   1);
      check("ld_dm_rdata",  bus.dm_rdata, 32'hCAFE_F00D);
      bus.dm_req = 1'b0;
      tick();

      // Store, 3-cycle memory: signals held 3 cycles, ack in cycle 5, dm_rdata kept
      lat          = 3;
      fixed_rdata  = 32'h5555_5555;
      bus.dm_addr  = 32'h10;
      bus.dm_we    = 1'b1;
      bus.dm_wdata = 32'hDEAD_BEEF;
      bus.dm_req   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("st_mem_req",   bus.mem_req,   1);
         check("st_mem_we",    bus.mem_we,    1);
         check("st_mem_addr",  bus.mem_addr,  32'h10);
         check("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      end
      tick();
      check("st_dm_ack_c5", bus.dm_ack,   1);
      check("st_if_ack_c5", bus.if_ack,   0);
      check("st_dm_rdata",  bus.dm_rdata, 32'hCAFE_F00D);
      bus.dm_req = 1'b0;
      bus.dm_we  = 1'b0;
      tick();

      // Spurious mem_ready in IDLE
      fixed_rdata = 32'h1234;
      spur_ready  = 1'b1;
      tick();
      spur_ready = 1'b0;
      check("sp_if_ack",  bus.if_ack,  0);
      check("sp_dm_ack",  bus.dm_ack,  0);
      check("sp_mem_req", bus.mem_req, 0);
      tick();
      check("sp_if_ack2",  bus.if_ack,   0);
      check("sp_dm_ack2",  bus.dm_ack,   0);
      check("sp_if_rdata", bus.if_rdata, 32'h2008_0005);
      check("sp_dm_rdata", bus.dm_rdata, 32'hCAFE_F00D);

      // Reset during GNT_DM, late mem_ready afterwards
      lat         = 10;
      bus.dm_addr = 32'h30;
      bus.dm_we   = 1'b0;
      bus.dm_req  = 1'b1;
      tick();
      check("rm_mem_req_gnt", bus.mem_req, 1);
      tick();
      rst        = 1'b1;
      bus.dm_req = 1'b0;
      #1;
      check("rm_mem_req_drop", bus.mem_req,  0);
      check("rm_dm_ack",       bus.dm_ack,   0);
      check("rm_dm_rdata",     bus.dm_rdata, 0);
      check("rm_if_rdata",     bus.if_rdata, 0);
      tick();
      rst         = 1'b0;
      fixed_rdata = 32'h9999;
      spur_ready  = 1'b1;
      tick();
      spur_ready = 1'b0;
      check("rm_late_dm_ack",  bus.dm_ack,   0);
      check("rm_late_if_ack",  bus.if_ack,   0);
      check("rm_late_mem_req", bus.mem_req,  0);
      check("rm_late_rdata",   bus.dm_rdata, 0);
      tick();
      check("rm_after_dm_ack", bus.dm_ack,   0);
      check("rm_after_rdata",  bus.dm_rdata, 0);

      // Simultaneous requests held for 3 rounds
`ifdef MEM_ARB_RR_EN
      exp_dm_win = 3'b010;
`else
      exp_dm_win = 3'b111;
`endif
      lat          = 1;
      fixed_rdata  = 32'hA5A5_0000;
      bus.if_addr  = 32'h100;
      bus.dm_addr  = 32'h200;
      bus.dm_we    = 1'b0;
      bus.if_req   = 1'b1;
      bus.dm_req   = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tick();
         check($sformatf("arb_addr_r%0d", r), bus.mem_addr, exp_dm_win[r] ? 32'h200 : 32'h100);
         tick();
         check($sformatf("arb_dm_ack_r%0d", r), bus.dm_ack, exp_dm_win[r]);
         check($sformatf("arb_if_ack_r%0d", r), bus.if_ack, !exp_dm_win[r]);
         tick();
      end
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      tick();

      // Randomized back-to-back traffic
      exp_if    = bus.if_rdata;
      exp_dm    = bus.dm_rdata;
`ifdef MEM_ARB_RR_EN
      exp_if = 32'hA5A5_0000;
      exp_dm = 32'hA5A5_0000;
`else
      exp_if = 32'h0;
      exp_dm = 32'hA5A5_0000;
`endif
      check("rnd_start_if_rdata", bus.if_rdata, exp_if);
      check("rnd_start_dm_rdata", bus.dm_rdata, exp_dm);
      use_hash  = 1'b1;
      rand_lat  = 1'b1;
      if_pend   = 1'b0;
      dm_pend   = 1'b0;
      if_issued = 0;
      if_acked  = 0;
      dm_issued = 0;
      dm_acked  = 0;
      cyc       = 0;
      while (cyc < 1000 || ((if_pend || dm_pend) && cyc < 1200)) begin
         tick();
         check("rnd_ack_overlap", bus.if_ack & bus.dm_ack, 0);
         if (bus.if_ack) begin
            check("rnd_if_ack_pending", if_pend, 1);
            exp_if = hash(bus.if_addr);
            check("rnd_if_rdata", bus.if_rdata, exp_if);
            if_pend    = 1'b0;
            if_acked++;
            bus.if_req = 1'b0;
         end
         if (bus.dm_ack) begin
            check("rnd_dm_ack_pending", dm_pend, 1);
            if (!bus.dm_we) exp_dm = hash(bus.dm_addr);
            check("rnd_dm_rdata", bus.dm_rdata, exp_dm);
            dm_pend    = 1'b0;
            dm_acked++;
            bus.dm_req = 1'b0;
            bus.dm_we  = 1'b0;
         end
         if (cyc < 1000) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
               bus.if_addr = $urandom;
               bus.if_req  = 1'b1;
               if_pend     = 1'b1;
               if_issued++;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
               bus.dm_addr  = $urandom;
               bus.dm_wdata = $urandom;
               bus.dm_we    = $urandom_range(0, 1) == 1;
               bus.dm_req   = 1'b1;
               dm_pend      = 1'b1;
               dm_issued++;
            end
         end
         cyc++;
      end
      check("rnd_drain_if", if_pend, 0);
      check("rnd_drain_dm", dm_pend, 0);
      check("rnd_if_count", if_acked, if_issued);
      check("rnd_dm_count", dm_acked, dm_issued);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
